// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter: N masters share one slave, grant held for a whole cyc.
// Optional watchdog turns a stalled slave access into a one-cycle err to the owner.
//   state | meaning
//   IDLE  | no grant, slave request driven to zero, picking next owner
//   BUSY  | owner's bus muxed to the slave until owner drops cyc
module wb_arbiter_rr #(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int num_masters = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst_n,
  input  logic [num_masters*aw-1:0]   wbm_adr_i,
  input  logic [num_masters*dw-1:0]   wbm_dat_i,
  input  logic [num_masters*dw/8-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]      wbm_we_i,
  input  logic [num_masters-1:0]      wbm_cyc_i,
  input  logic [num_masters-1:0]      wbm_stb_i,
  input  logic [num_masters*3-1:0]    wbm_cti_i,
  input  logic [num_masters*2-1:0]    wbm_bte_i,
  output logic [dw-1:0]               wbm_dat_o,
  output logic [num_masters-1:0]      wbm_ack_o,
  output logic [num_masters-1:0]      wbm_err_o,
  output logic [num_masters-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i
);

  localparam int SW = dw / 8;
  localparam int IW = (num_masters > 2) ? $clog2(num_masters) : 1;
  localparam logic [15:0] WDT_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [15:0]     wdt_q, wdt_d;
  logic            to_err_q, to_err_d;

  logic            own_cyc;
  logic            own_stb;
  logic            slv_resp;
  logic [IW-1:0]   pick;

  // Scan last+1 .. last+num_masters; iterating downwards lets the nearest requester win.
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] last,
                                            input logic [num_masters-1:0] req);
    logic [IW-1:0]          res;
    logic [num_masters-1:0] sh;
    int                     idx;
    res = last;
    for (int k = num_masters; k >= 1; k--) begin
      idx = (int'(last) + k) % num_masters;
      sh  = req >> idx;
      if (sh[0]) res = IW'(idx);
    end
    return res;
  endfunction

  always_comb begin
    pick     = rr_pick(last_q, wbm_cyc_i);
    own_cyc  = wbm_cyc_i[owner_q];
    own_stb  = wbm_stb_i[owner_q];
    slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(num_masters - 1);
      wdt_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wdt_q    <= wdt_d;
      to_err_q <= to_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wdt_d    = wdt_q;
    to_err_d = to_err_q;
    case (state_q)
      IDLE: begin
        wdt_d    = '0;
        to_err_d = 1'b0;
        if (|wbm_cyc_i) begin
          owner_d = pick;
          last_d  = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The err pulse lasts exactly one cycle; counting restarts after it.
        to_err_d = 1'b0;
        if ((TIMEOUT > 0) && own_stb && !to_err_q && !slv_resp) begin
          if (wdt_q == WDT_LAST) begin
            to_err_d = 1'b1;
            wdt_d    = '0;
          end else begin
            wdt_d = wdt_q + 16'd1;
          end
        end else begin
          wdt_d = '0;
        end
        if (!own_cyc) begin
          state_d  = IDLE;
          wdt_d    = '0;
          to_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wbm_dat_o = wbs_dat_i;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (state_q == BUSY) begin
      wbs_adr_o = wbm_adr_i[int'(owner_q)*aw +: aw];
      wbs_dat_o = wbm_dat_i[int'(owner_q)*dw +: dw];
      wbs_sel_o = wbm_sel_i[int'(owner_q)*SW +: SW];
      wbs_cti_o = wbm_cti_i[int'(owner_q)*3 +: 3];
      wbs_bte_o = wbm_bte_i[int'(owner_q)*2 +: 2];
      wbs_we_o  = wbm_we_i[owner_q];
      wbs_cyc_o = own_cyc;
      wbs_stb_o = own_stb & ~to_err_q;
      wbm_ack_o[owner_q] = wbs_ack_i & ~to_err_q;
      wbm_err_o[owner_q] = wbs_err_i | to_err_q;
      wbm_rty_o[owner_q] = wbs_rty_i & ~to_err_q;
    end
  end

endmodule
